uc_sequencer: RTL and testbench



---
 rtl/uc_pkg.sv | 36 +++
 rtl/uc_decode.sv | 42 ++++
 rtl/uc_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_uc_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types and encodings for the UT control unit.
package uc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    F_REQ,
    F_LD,
    PC_A,
    PC_B,
    PC_W,
    DEC,
    RS1,
    OP2,
    WB,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_ADDI,
    OP_ILL
  } op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  // Only x0..x3 exist in the UT register file.
  localparam logic [4:0] MAX_REG    = 5'd3;

  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/uc_decode.sv
// Combinational decode of the UT instruction register into operation and register indices.
module uc_decode
  import uc_pkg::*;
(
  input  logic [31:0] instr,
  output op_t         op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       regs_bad;

  // Field extraction, operation match and register-range check.
  always_comb begin
    opcode = instr[6:0];
    rd     = instr[11:7];
    funct3 = instr[14:12];
    rs1    = instr[19:15];
    rs2    = instr[24:20];
    funct7 = instr[31:25];

    op = OP_ILL;
    if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_ADD) begin
      op = OP_ADD;
    end else if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_SUB) begin
      op = OP_SUB;
    end else if (opcode == OPC_OP_IMM && funct3 == F3_ADD) begin
      op = OP_ADDI;
    end

    // rs2 only matters for R-type; ADDI carries immediate bits there.
    regs_bad = (rs1 > MAX_REG) || (rd > MAX_REG) ||
               ((op == OP_ADD || op == OP_SUB) && (rs2 > MAX_REG));
    illegal  = (op == OP_ILL) || regs_bad;
  end

endmodule

// File: rtl/uc_sequencer.sv
// Multi-cycle control unit driving the UT datapath: fetch, PC+4, decode, execute.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | stopped at an instruction boundary, waiting for run
//   F_REQ | PC on bus, memory request outstanding, timeout running
//   F_LD  | fetched word onto rd_data, loaded into UT IR
//   PC_A  | PC into ALU operand A
//   PC_B  | constant 4 into ALU operand B
//   PC_W  | ALU sum written back to PC
//   DEC   | classify IR contents, trap on illegal
//   RS1   | register rs1 into operand A
//   OP2   | immediate or register rs2 into operand B
//   WB    | ALU result into rd, capture carry, retire
//   TRAP  | fault, held until reset
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic [31:0]        rd_data,
  input  logic [31:0]        instr,
  input  logic               ALU_carry,
  output logic               sel_alu_func,
  output logic               ir_en,
  output logic               immgen_bus_en,
  output logic               ALU_bus_en,
  output logic               a_en,
  output logic               b_en,
  output logic               pc_en,
  output logic               pc_bus_en,
  output logic               rf_wen,
  output logic               rf_ren,
  output logic               rf_bus_en,
  output logic               rd_bus_en,
  output logic [4:0]         rf_addr_sel,
  output logic               carry_flag,
  output logic               trap,
  output logic               busy,
  output logic [COUNT_W-1:0] instr_count
);

  // Down-counter reloaded on every fetch; trap when it hits zero with no ack.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [31:0]          latch_q, latch_d;
  logic                 carry_q, carry_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  op_t                  op;
  logic [4:0]           rs1, rs2, rd;
  logic                 illegal;

  uc_decode u_decode (
    .instr   (instr),
    .op      (op),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .illegal (illegal)
  );

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      latch_q <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      latch_q <= latch_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  // Next-state, fetch timeout, instruction latch and retirement bookkeeping.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    latch_d = latch_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = F_REQ;
          wait_d  = WAIT_LOAD;
        end
      end
      F_REQ: begin
        if (mem_ack) begin
          latch_d = mem_rdata;
          state_d = F_LD;
        end else if (wait_q == '0) begin
          state_d = TRAP;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      F_LD:  state_d = PC_A;
      PC_A:  state_d = PC_B;
      PC_B:  state_d = PC_W;
      PC_W:  state_d = DEC;
      DEC:   state_d = illegal ? TRAP : RS1;
      RS1:   state_d = OP2;
      OP2:   state_d = WB;
      WB: begin
        carry_d = ALU_carry;
        count_d = count_q + COUNT_W'(1);
        if (run) begin
          state_d = F_REQ;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Moore control decode: exactly one bus driver per cycle at most.
  always_comb begin
    mem_req       = 1'b0;
    sel_alu_func  = 1'b0;
    ir_en         = 1'b0;
    immgen_bus_en = 1'b0;
    ALU_bus_en    = 1'b0;
    a_en          = 1'b0;
    b_en          = 1'b0;
    pc_en         = 1'b0;
    pc_bus_en     = 1'b0;
    rf_wen        = 1'b0;
    rf_ren        = 1'b0;
    rf_bus_en     = 1'b0;
    rd_bus_en     = 1'b0;
    rf_addr_sel   = 5'd0;
    trap          = 1'b0;
    case (state_q)
      F_REQ: begin
        pc_bus_en = 1'b1;
        mem_req   = 1'b1;
      end
      F_LD: begin
        rd_bus_en = 1'b1;
        ir_en     = 1'b1;
      end
      PC_A: begin
        pc_bus_en = 1'b1;
        a_en      = 1'b1;
      end
      PC_B: begin
        rd_bus_en = 1'b1;
        b_en      = 1'b1;
      end
      PC_W: begin
        ALU_bus_en = 1'b1;
        pc_en      = 1'b1;
      end
      RS1: begin
        rf_addr_sel = rs1;
        rf_ren      = 1'b1;
        rf_bus_en   = 1'b1;
        a_en        = 1'b1;
      end
      OP2: begin
        b_en = 1'b1;
        if (op == OP_ADDI) begin
          immgen_bus_en = 1'b1;
        end else begin
          rf_addr_sel = rs2;
          rf_ren      = 1'b1;
          rf_bus_en   = 1'b1;
        end
      end
      WB: begin
        ALU_bus_en   = 1'b1;
        sel_alu_func = (op == OP_SUB);
        rf_addr_sel  = rd;
        rf_wen       = (rd != 5'd0);
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign rd_data     = (state_q == PC_B) ? PC_STEP : latch_q;
  assign busy        = (state_q != IDLE) && (state_q != TRAP);
  assign carry_flag  = carry_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// Scoreboard bench for uc_sequencer: stimulus queues per-cycle expected controls, monitor compares.
module tb_uc_sequencer;

  localparam int CW = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          run;
  logic          mem_req;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [31:0]   rd_data;
  logic [31:0]   instr;
  logic          ALU_carry;
  logic          sel_alu_func, ir_en, immgen_bus_en, ALU_bus_en, a_en, b_en;
  logic          pc_en, pc_bus_en, rf_wen, rf_ren, rf_bus_en, rd_bus_en;
  logic [4:0]    rf_addr_sel;
  logic          carry_flag, trap, busy;
  logic [CW-1:0] instr_count;

  uc_sequencer #(.COUNT_W(CW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .rd_data       (rd_data),
    .instr         (instr),
    .ALU_carry     (ALU_carry),
    .sel_alu_func  (sel_alu_func),
    .ir_en         (ir_en),
    .immgen_bus_en (immgen_bus_en),
    .ALU_bus_en    (ALU_bus_en),
    .a_en          (a_en),
    .b_en          (b_en),
    .pc_en         (pc_en),
    .pc_bus_en     (pc_bus_en),
    .rf_wen        (rf_wen),
    .rf_ren        (rf_ren),
    .rf_bus_en     (rf_bus_en),
    .rd_bus_en     (rd_bus_en),
    .rf_addr_sel   (rf_addr_sel),
    .carry_flag    (carry_flag),
    .trap          (trap),
    .busy          (busy),
    .instr_count   (instr_count)
  );

  typedef struct packed {
    logic          mem_req, sel_alu_func, ir_en, immgen_bus_en, alu_bus_en, a_en, b_en;
    logic          pc_en, pc_bus_en, rf_wen, rf_ren, rf_bus_en, rd_bus_en;
    logic [4:0]    rf_addr_sel;
    logic [31:0]   rd_data;
    logic          carry_flag;
    logic [CW-1:0] instr_count;
  } obs_t;

  typedef struct packed {
    logic [31:0] w;
    logic        c;
  } prog_t;

  obs_t    exp_q[$];
  prog_t   prog_q[$];
  obs_t    obs_now;
  obs_t    exp_item;
  prog_t   p;
  int      checks = 0;
  int      failures = 0;
  int      seq_idx = 0;

  logic [31:0]   exp_latch = '0;
  logic          exp_carry = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  // Reset-phase input toggling muxed in front of the memory/UT models.
  logic        tog_mode = 1'b1;
  logic        tog_ack = 1'b0;
  logic [31:0] tog_word = '0;
  logic        tog_carry = 1'b0;
  logic        ack_r = 1'b0;
  logic [31:0] rdata_r = '0;
  logic        carry_r = 1'b0;
  logic        resp_en = 1'b1;
  logic [31:0] ir_q;

  assign mem_ack   = tog_mode ? tog_ack   : ack_r;
  assign mem_rdata = tog_mode ? tog_word  : rdata_r;
  assign ALU_carry = tog_mode ? tog_carry : carry_r;
  assign instr     = tog_mode ? tog_word  : ir_q;

  assign obs_now = {mem_req, sel_alu_func, ir_en, immgen_bus_en, ALU_bus_en, a_en, b_en,
                    pc_en, pc_bus_en, rf_wen, rf_ren, rf_bus_en, rd_bus_en,
                    rf_addr_sel, rd_data, carry_flag, instr_count};

  logic [56:0] all_outs;
  assign all_outs = {mem_req, rd_data, sel_alu_func, ir_en, immgen_bus_en, ALU_bus_en, a_en,
                     b_en, pc_en, pc_bus_en, rf_wen, rf_ren, rf_bus_en, rd_bus_en,
                     rf_addr_sel, carry_flag, trap, busy, instr_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UT instruction register model.
  always @(posedge clk) if (ir_en) ir_q <= rd_data;

  // Memory model: answers a request with a one-cycle ack pulse one cycle later.
  always @(negedge clk) begin
    if (ack_r) begin
      ack_r = 1'b0;
    end else if (rst && resp_en && mem_req && prog_q.size() > 0) begin
      p = prog_q.pop_front();
      rdata_r = p.w;
      carry_r = p.c;
      ack_r = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every busy cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      chk("bus_excl", 64'($countones({immgen_bus_en, ALU_bus_en, pc_bus_en, rf_bus_en, rd_bus_en}) <= 1), 64'd1);
      chk("rf_rw_excl", 64'(rf_wen & rf_ren), 64'd0);
      chk("ir_a_excl", 64'(ir_en & a_en), 64'd0);
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_busy", 64'(obs_now), 64'd0);
        end else begin
          exp_item = exp_q.pop_front();
          chk($sformatf("seq%0d", seq_idx), 64'(obs_now), 64'(exp_item));
          seq_idx++;
        end
      end
    end
  end

  function automatic obs_t base_obs();
    obs_t o;
    o = '0;
    o.rd_data = exp_latch;
    o.carry_flag = exp_carry;
    o.instr_count = exp_cnt;
    return o;
  endfunction

  // Queue the per-cycle controls for one instruction (first ncyc cycles) and its memory word.
  task automatic push_instr(input logic [31:0] w, input logic c, input logic [4:0] a1,
                            input logic [4:0] a2, input logic [4:0] ad, input bit is_r,
                            input logic sel, input logic wen, input int ncyc);
    obs_t s[9];
    s[0] = base_obs();
    s[0].mem_req = 1'b1;
    s[0].pc_bus_en = 1'b1;
    exp_latch = w;
    for (int k = 1; k < 9; k++) s[k] = base_obs();
    s[1].rd_bus_en = 1'b1;  s[1].ir_en = 1'b1;
    s[2].pc_bus_en = 1'b1;  s[2].a_en = 1'b1;
    s[3].rd_bus_en = 1'b1;  s[3].b_en = 1'b1;  s[3].rd_data = 32'd4;
    s[4].alu_bus_en = 1'b1; s[4].pc_en = 1'b1;
    s[6].rf_addr_sel = a1;  s[6].rf_ren = 1'b1; s[6].rf_bus_en = 1'b1; s[6].a_en = 1'b1;
    s[7].b_en = 1'b1;
    if (is_r) begin
      s[7].rf_addr_sel = a2; s[7].rf_ren = 1'b1; s[7].rf_bus_en = 1'b1;
    end else begin
      s[7].immgen_bus_en = 1'b1;
    end
    s[8].alu_bus_en = 1'b1; s[8].sel_alu_func = sel; s[8].rf_addr_sel = ad; s[8].rf_wen = wen;
    for (int k = 0; k < ncyc; k++) exp_q.push_back(s[k]);
    if (ncyc == 9) begin
      exp_carry = c;
      exp_cnt = exp_cnt + 1'b1;
    end
    prog_q.push_back({w, c});
  endtask

  // Wait for the scoreboard to empty; optionally drop run once only WB remains.
  task automatic drain(input bit drop_run, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
      if (drop_run && exp_q.size() <= 1) run = 1'b0;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    #1;
    chk("reset_outs", 64'(all_outs), 64'd0);
    exp_latch = '0;
    exp_carry = 1'b0;
    exp_cnt = '0;
    prog_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;

    // Reset held while every input toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tog_ack = 1'($urandom_range(0, 1));
      tog_word = $urandom;
      tog_carry = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      #1;
      chk("reset_toggle", 64'(all_outs), 64'd0);
    end

    // ADDI x1,x0,5 ; SUB x3,x1,x2 (carry 1) ; ADD x0,x1,x2, run dropped in last OP2.
    push_instr(32'h00500093, 1'b0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 9);
    push_instr(32'h402081B3, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 9);
    push_instr(32'h00208033, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 9);
    @(negedge clk);
    tog_mode = 1'b0;
    run = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("first_fetch", 64'({mem_req, pc_bus_en}), 64'b11);
    drain(1'b1, 100);
    repeat (2) @(negedge clk);
    #1;
    chk("idle_after_drop", 64'({busy, mem_req, trap}), 64'd0);
    chk("count_after3", 64'(instr_count), 64'd3);
    chk("carry_after_add", 64'(carry_flag), 64'd0);

    // Async reset in RS1 of ADDI x2,x0,7.
    push_instr(32'h00700113, 1'b0, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 7);
    @(negedge clk);
    run = 1'b1;
    drain(1'b0, 50);
    rst = 1'b0;
    #1;
    chk("async_reset_rs1", 64'(all_outs), 64'd0);
    exp_latch = '0;
    exp_carry = 1'b0;
    exp_cnt = '0;
    prog_q.delete();
    @(negedge clk);
    run = 1'b0;
    rst = 1'b1;

    // ADDI x5,x0,1 uses an out-of-range register: trap after DEC.
    push_instr(32'h00100293, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 6);
    @(negedge clk);
    run = 1'b1;
    drain(1'b0, 50);
    repeat (2) @(negedge clk);
    #1;
    chk("illegal_trap", 64'({trap, busy, mem_req}), 64'b100);
    repeat (5) @(negedge clk);
    #1;
    chk("trap_sticky", 64'({trap, busy, mem_req}), 64'b100);
    do_reset();

    // Memory never answers: exactly TO request cycles, then trap.
    resp_en = 1'b0;
    for (int k = 0; k < TO; k++) begin
      exp_item = base_obs();
      exp_item.mem_req = 1'b1;
      exp_item.pc_bus_en = 1'b1;
      exp_q.push_back(exp_item);
    end
    @(negedge clk);
    run = 1'b1;
    drain(1'b0, 50);
    repeat (2) @(negedge clk);
    #1;
    chk("timeout_trap", 64'({trap, busy, mem_req}), 64'b100);
    do_reset();
    resp_en = 1'b1;

    // Stream of 2^CW ADDI x1,x1,1: counter wraps to 0.
    for (int i = 0; i < 16; i++)
      push_instr(32'h00108093, 1'((i % 2) == 1), 5'd1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 9);
    @(negedge clk);
    run = 1'b1;
    drain(1'b1, 400);
    repeat (2) @(negedge clk);
    #1;
    chk("count_wrap", 64'(instr_count), 64'd0);
    chk("wrap_idle", 64'({busy, carry_flag}), 64'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
